uart_tx_dev: RTL and testbench
==============================

Name: uart_tx_dev

Overview:
- Memory-mapped UART transmitter peripheral and bus responder on the shared processor bus.
- The CPU is the initiator. This block decodes memAddr/we/re, accepts bytes into a small FIFO, and serialises them 8N1 on a tx pin.
- It drives its read data onto an OR-combined data bus: zero when not addressed.
- It raises inta_ready for the system interrupt logic, alongside the existing key/switch/timer devices.

Parameters:
- BITS, 32, bus data/address width.
- BASE, 32'hF0000030, DATA register address.
- CTRL_BASE, 32'hF0000130, CTRL/STATUS register address.
- BAUD_DIV, 217, clock cycles per serial bit (25 MHz / 115200). Legal range 2..65535.
- FIFO_DEPTH, 8, transmit FIFO entries. Power of two, 2..64.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  bus write enable.
- re  in  1  bus read enable.
- memAddr  in  BITS  bus address.
- dataBusIn  in  BITS  bus data (CPU write data).
- dataBusOut  out  BITS  read data; all zeros unless this block is addressed.
- tx  out  1  serial output, idle high.
- inta_ready  out  1  interrupt request, level.

Behaviour:

Reset (asynchronous, active-high):
- tx=1, inta_ready=0, FIFO empty, state IDLE.
- ie=0, ovr=0, baud and bit counters 0.
- Reset mid-frame aborts the frame; tx returns high immediately.

DATA register (BASE):
- Write (we=1): push dataBusIn[7:0] at the clock edge.
- Read: returns {BITS-8 zeros, 8-bit FIFO count}.

CTRL register (CTRL_BASE):
- bit0 rdy = FIFO not full.
- bit1 busy = state != IDLE.
- bit2 ovr = sticky overrun.
- bit3 empty = FIFO empty and not busy.
- bit8 ie = interrupt enable.
- Write: ie <= dataBusIn[8]; ovr cleared if dataBusIn[2]=0; all other bits ignored.
- Read with re=1 at an edge clears ovr. The value returned that cycle still shows ovr=1.

dataBusOut:
- Combinational: register value when memAddr == BASE or CTRL_BASE and we=0; otherwise 0.
- Any other address: ignored, output 0.

Overflow:
- Write to DATA while full with no pop in the same cycle: byte dropped, ovr<=1.
- Full, with a write and a pop in the same cycle: write accepted, count unchanged, ovr unchanged.

FSM (IDLE, START, DATA, STOP):
- IDLE: if FIFO non-empty, pop at the edge → START; tx=0, baud counter=0.
  - A byte written at edge N into an empty FIFO in IDLE is popped at edge N+1, and tx falls after edge N+1.
- START: after BAUD_DIV cycles → DATA, bit index 0.
- DATA: tx = shift[bit index], LSB first. Each bit lasts BAUD_DIV cycles. After bit 7 → STOP.
- STOP: tx=1 for BAUD_DIV cycles. At the end: if FIFO non-empty, pop → START (back-to-back, no gap); else → IDLE.
- Frame length is exactly 10*BAUD_DIV cycles.
- Baud counter width is clog2(BAUD_DIV). It wraps to 0 at BAUD_DIV-1.

Interrupt:
- inta_ready = ie & (FIFO empty) & (state == IDLE), registered (one-cycle latency).
- It is cleared by disabling ie or by writing new data.
- No idn logic here; priority encoding belongs to the top level.

FIFO:
- Circular buffer with a count register of clog2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, STOP);
  - CTRL bit positions (RDY=0, BUSY=1, OVR=2, EMPTY=3, IE=8);
  - default BAUD_DIV constant.
- One sub-module, tx_fifo: sync push/pop, full/empty/count, async active-high reset. Parameterised by width 8 and FIFO_DEPTH.
- The bus decode and FSM stay in uart_tx_dev.

Test Plan (BAUD_DIV=4, FIFO_DEPTH=4):
1. Reset asserted mid-frame → tx=1 within the same cycle. CTRL read = 0x0000_0009 (rdy, empty); DATA read = 0.
2. Write 0xA5 to DATA → tx low at the edge after the write.
   - Serial bits 1,0,1,0,0,1,0,1 then stop=1, each held 4 cycles.
   - Total frame 40 cycles; busy=0 afterwards.
3. Write 0x11, 0x22, 0x33 back-to-back.
   - Three frames with no idle cycle between stop and next start; 120 cycles total.
   - DATA read reports count 2 right after the first pop.
4. Fill the FIFO with 4 bytes plus one in flight, then write 0x77 → byte dropped, CTRL bit2=1.
   - CTRL read with re=1 returns bit2=1; the next read returns bit2=0.
   - 0x77 never appears on tx.
5. Write CTRL 0x100, then write one byte.
   - inta_ready=0 during the frame.
   - inta_ready=1 one cycle after return to IDLE.
   - Writing CTRL 0x000 drops inta_ready.
6. Access address BASE+8 with we=1 and data 0xFF → no state change; dataBusOut stays 0 for all non-matching addresses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

    // Transmit state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // CTRL/STATUS register bit positions
    localparam int CTRL_RDY   = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_OVR   = 2;
    localparam int CTRL_EMPTY = 3;
    localparam int CTRL_IE    = 8;

    // 25 MHz system clock, 115200 baud
    localparam int DEFAULT_BAUD_DIV = 217;

endpackage

// File: rtl/tx_fifo.sv
// Circular transmit FIFO with occupancy count; push and pop may coincide.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // A push into a full FIFO is only accepted when a pop frees a slot that cycle
    assign w_push_ok = push & (~full | pop);
    assign w_pop_ok  = pop & ~empty;

    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rptr];

    // Storage array carries data only, so it is left out of reset
    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: bus decode, status/control, serialiser FSM.
module uart_tx_dev
    import uart_pkg::*;
#(
    parameter int              BITS       = 32,
    parameter logic [BITS-1:0] BASE       = 32'hF0000030,
    parameter logic [BITS-1:0] CTRL_BASE  = 32'hF0000130,
    parameter int              BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int              FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic            re,
    input  logic [BITS-1:0] memAddr,
    input  logic [BITS-1:0] dataBusIn,
    output logic [BITS-1:0] dataBusOut,
    output logic            tx,
    output logic            inta_ready
);

    localparam int               CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam int               CW       = $clog2(FIFO_DEPTH) + 1;

    uart_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_shift;
    logic             r_ie;
    logic             r_ovr;
    logic             r_inta;

    logic             w_sel_data, w_sel_ctrl;
    logic             w_wr_data, w_wr_ctrl, w_rd_ctrl;
    logic             w_pop, w_ovf, w_cnt_last;
    logic             w_full, w_empty;
    logic [7:0]       w_rd_byte;
    logic [CW-1:0]    w_count;
    logic             w_unused_bits;

    assign w_sel_data = (memAddr == BASE);
    assign w_sel_ctrl = (memAddr == CTRL_BASE);
    assign w_wr_data  = we & w_sel_data;
    assign w_wr_ctrl  = we & w_sel_ctrl;
    assign w_rd_ctrl  = re & ~we & w_sel_ctrl;
    // A write to a full FIFO is lost unless the serialiser pops in the same cycle
    assign w_ovf      = w_wr_data & w_full & ~w_pop;
    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign inta_ready = r_inta;
    assign w_unused_bits = ^dataBusIn[BITS-1:9];

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_wr_data),
        .pop     (w_pop),
        .wr_data (dataBusIn[7:0]),
        .rd_data (w_rd_byte),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // FSM state, baud counter and bit index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    // Next-state, FIFO pop and serial line value; tx is decoded from state so reset forces it high at once
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_last ? '0 : r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_pop       = 1'b0;
        tx          = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                tx = 1'b0;
                if (w_cnt_last) begin
                    w_state_nxt = ST_DATA;
                    w_bit_nxt   = 3'd0;
                end
            end
            ST_DATA: begin
                tx = r_shift[r_bit];
                if (w_cnt_last) begin
                    if (r_bit == 3'd7)
                        w_state_nxt = ST_STOP;
                    else
                        w_bit_nxt = r_bit + 3'd1;
                end
            end
            ST_STOP: begin
                if (w_cnt_last) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture the byte being serialised whenever the FSM pops the FIFO
    always_ff @(posedge clk) begin
        if (w_pop)
            r_shift <= w_rd_byte;
    end

    // Interrupt enable, sticky overrun and registered interrupt level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ie   <= 1'b0;
            r_ovr  <= 1'b0;
            r_inta <= 1'b0;
        end else begin
            if (w_wr_ctrl)
                r_ie <= dataBusIn[CTRL_IE];
            if (w_ovf)
                r_ovr <= 1'b1;
            else if (w_wr_ctrl && !dataBusIn[CTRL_OVR])
                r_ovr <= 1'b0;
            else if (w_rd_ctrl)
                r_ovr <= 1'b0;
            r_inta <= r_ie & w_empty & (r_state == ST_IDLE);
        end
    end

    // Read mux onto the OR-combined bus; zero whenever this block is not being read
    always_comb begin
        dataBusOut = '0;
        if (!we) begin
            if (w_sel_data) begin
                dataBusOut = BITS'(w_count);
            end else if (w_sel_ctrl) begin
                dataBusOut[CTRL_RDY]   = ~w_full;
                dataBusOut[CTRL_BUSY]  = (r_state != ST_IDLE);
                dataBusOut[CTRL_OVR]   = r_ovr;
                dataBusOut[CTRL_EMPTY] = w_empty & (r_state == ST_IDLE);
                dataBusOut[CTRL_IE]    = r_ie;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev with BAUD_DIV=4, FIFO_DEPTH=4.
module tb_uart_tx_dev;

    localparam logic [31:0] BASE      = 32'hF0000030;
    localparam logic [31:0] CTRL_BASE = 32'hF0000130;

    logic        clk;
    logic        reset;
    logic        we;
    logic        re;
    logic [31:0] memAddr;
    logic [31:0] dataBusIn;
    logic [31:0] dataBusOut;
    logic        tx;
    logic        inta_ready;

    int n_checks;
    int n_errors;

    uart_tx_dev #(
        .BITS       (32),
        .BASE       (BASE),
        .CTRL_BASE  (CTRL_BASE),
        .BAUD_DIV   (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .re         (re),
        .memAddr    (memAddr),
        .dataBusIn  (dataBusIn),
        .dataBusOut (dataBusOut),
        .tx         (tx),
        .inta_ready (inta_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Expected line level k cycles into a frame of 4-cycle bits
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k < 4)       return 1'b0;
        else if (k < 36) return b[(k - 4) / 4];
        else             return 1'b1;
    endfunction

    // All tasks are entered and left on a falling edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        memAddr   = a;
        dataBusIn = d;
        we        = 1'b1;
        @(negedge clk);
        we        = 1'b0;
        memAddr   = '0;
        dataBusIn = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        memAddr = a;
        re      = 1'b1;
        #1 d = dataBusOut;
        @(negedge clk);
        re      = 1'b0;
        memAddr = '0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        memAddr = a;
        #1 d = dataBusOut;
        memAddr = '0;
    endtask

    task automatic check_frame(input logic [7:0] b, input int from);
        for (int k = from; k < 40; k++) begin
            @(negedge clk);
            check_val($sformatf("tx_%02h_k%0d", b, k), {31'b0, tx}, {31'b0, frame_bit(b, k)});
            check_val($sformatf("inta_frame_%02h_k%0d", b, k), {31'b0, inta_ready}, 32'd0);
        end
    endtask

    logic [31:0] rd;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        we        = 1'b0;
        re        = 1'b0;
        memAddr   = '0;
        dataBusIn = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: reset values, then reset in the middle of a frame
        peek(CTRL_BASE, rd);
        check_val("ctrl_after_reset", rd, 32'h9);
        check_val("tx_after_reset", {31'b0, tx}, 32'd1);
        check_val("inta_after_reset", {31'b0, inta_ready}, 32'd0);
        bus_write(BASE, 32'hF0);
        repeat (9) @(negedge clk);
        check_val("tx_mid_frame", {31'b0, tx}, {31'b0, frame_bit(8'hF0, 8)});
        #2 reset = 1'b1;
        #1 check_val("tx_async_reset", {31'b0, tx}, 32'd1);
        peek(CTRL_BASE, rd);
        check_val("ctrl_in_reset", rd, 32'h9);
        peek(BASE, rd);
        check_val("data_in_reset", rd, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("tx_after_abort", {31'b0, tx}, 32'd1);

        // 2: single frame
        bus_write(BASE, 32'hA5);
        check_val("tx_idle_at_write", {31'b0, tx}, 32'd1);
        check_frame(8'hA5, 0);
        @(negedge clk);
        peek(CTRL_BASE, rd);
        check_val("ctrl_after_a5", rd, 32'h9);

        // 3: three back-to-back frames
        bus_write(BASE, 32'h11);
        check_val("tx_idle_b2b", {31'b0, tx}, 32'd1);
        bus_write(BASE, 32'h22);
        check_val("tx_11_k0", {31'b0, tx}, 32'd0);
        bus_write(BASE, 32'h33);
        check_val("tx_11_k1", {31'b0, tx}, 32'd0);
        peek(BASE, rd);
        check_val("count_two", rd, 32'd2);
        check_frame(8'h11, 2);
        check_frame(8'h22, 0);
        check_frame(8'h33, 0);
        @(negedge clk);
        peek(CTRL_BASE, rd);
        check_val("ctrl_after_b2b", rd, 32'h9);

        // 4: overflow while full and a frame in flight
        bus_write(BASE, 32'h81);
        bus_write(BASE, 32'h42);
        bus_write(BASE, 32'h24);
        bus_write(BASE, 32'h18);
        bus_write(BASE, 32'hC3);
        peek(BASE, rd);
        check_val("count_full", rd, 32'd4);
        bus_write(BASE, 32'h77);
        bus_read(CTRL_BASE, rd);
        check_val("ctrl_ovr_set", rd, 32'h6);
        bus_read(CTRL_BASE, rd);
        check_val("ctrl_ovr_cleared", rd, 32'h2);
        check_frame(8'h81, 7);
        check_frame(8'h42, 0);
        check_frame(8'h24, 0);
        check_frame(8'h18, 0);
        check_frame(8'hC3, 0);
        @(negedge clk);
        peek(CTRL_BASE, rd);
        check_val("ctrl_after_ovf", rd, 32'h9);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val($sformatf("tx_no_77_%0d", i), {31'b0, tx}, 32'd1);
        end

        // 5: interrupt enable and latency
        bus_write(CTRL_BASE, 32'h100);
        check_val("inta_reg_latency", {31'b0, inta_ready}, 32'd0);
        bus_write(BASE, 32'h3C);
        check_val("inta_up_before_pop", {31'b0, inta_ready}, 32'd1);
        check_frame(8'h3C, 0);
        @(negedge clk);
        check_val("inta_idle_latency", {31'b0, inta_ready}, 32'd0);
        peek(CTRL_BASE, rd);
        check_val("ctrl_ie_set", rd, 32'h109);
        @(negedge clk);
        check_val("inta_raised", {31'b0, inta_ready}, 32'd1);
        bus_write(CTRL_BASE, 32'h0);
        check_val("inta_hold_one", {31'b0, inta_ready}, 32'd1);
        @(negedge clk);
        check_val("inta_dropped", {31'b0, inta_ready}, 32'd0);

        // 6: foreign addresses are ignored and read as zero
        bus_write(BASE + 32'd8, 32'hFF);
        peek(BASE, rd);
        check_val("count_foreign_wr", rd, 32'd0);
        peek(CTRL_BASE, rd);
        check_val("ctrl_foreign_wr", rd, 32'h9);
        repeat (2) @(negedge clk);
        check_val("tx_foreign_wr", {31'b0, tx}, 32'd1);
        peek(BASE + 32'd8, rd);
        check_val("out_base_p8", rd, 32'd0);
        peek(CTRL_BASE + 32'd4, rd);
        check_val("out_ctrl_p4", rd, 32'd0);
        peek(32'h0, rd);
        check_val("out_zero_addr", rd, 32'd0);
        peek(BASE ^ 32'h1000_0000, rd);
        check_val("out_alias", rd, 32'd0);
        bus_read(BASE + 32'd8, rd);
        check_val("out_re_foreign", rd, 32'd0);
        memAddr   = CTRL_BASE;
        dataBusIn = 32'h0;
        we        = 1'b1;
        #1 check_val("out_during_write", dataBusOut, 32'd0);
        @(negedge clk);
        we      = 1'b0;
        memAddr = '0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
